alu_seq_exec: RTL

- Multi-cycle execute unit that consumes the 4-bit alu_ctrl code produced by the ALU control decoder and performs the selected operation on two XLEN-bit operands.
- Logical, arithmetic and compare ops complete in one cycle.
- Shifts use an iterative 1-bit-per-cycle shifter to save area.
- Sits in the EX stage behind a valid/ready handshake on both the operand side and the result side.

---
 rtl/alu_seq_exec.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_seq_exec.sv
// EX-stage execute unit: logic/arith/compare in 1 cycle, shifts iterate 1 bit per cycle.
// Latency 1 (shift: shamt+1); one op in flight, in_ready only when idle, result held until out_ready.
module alu_seq_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } sh_kind_t;

    state_t          state;
    sh_kind_t        sh_kind;
    sh_kind_t        sh_kind_in;
    logic [XLEN-1:0] sh_reg;
    logic [XLEN-1:0] sh_next;
    logic [SHW-1:0]  sh_cnt;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            is_shift;
    logic [XLEN:0]   diff_u;
    logic            lt_u;
    logic            lt_s;
    logic [XLEN-1:0] alu_res;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = op_b[SHW-1:0];
    assign is_shift  = (alu_ctrl == 4'd7) || (alu_ctrl == 4'd8) || (alu_ctrl == 4'd9);

    // One XLEN+1-bit subtraction serves SUB, SLTU (borrow) and SLT (sign-extended top bit).
    assign diff_u = {1'b0, op_a} - {1'b0, op_b};
    assign lt_u   = diff_u[XLEN];
    assign lt_s   = diff_u[XLEN] ^ op_a[XLEN-1] ^ op_b[XLEN-1];

    always_comb begin
        alu_res = op_a + op_b;
        case (alu_ctrl)
            4'd1:    alu_res = diff_u[XLEN-1:0];
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, lt_s};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, lt_u};
            4'd7,
            4'd8,
            4'd9:    alu_res = op_a;
            default: alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        sh_kind_in = SH_LL;
        case (alu_ctrl)
            4'd8:    sh_kind_in = SH_RL;
            4'd9:    sh_kind_in = SH_RA;
            default: sh_kind_in = SH_LL;
        endcase
    end

    always_comb begin
        sh_next = sh_reg;
        case (sh_kind)
            SH_LL:   sh_next = {sh_reg[XLEN-2:0], 1'b0};
            SH_RL:   sh_next = {1'b0, sh_reg[XLEN-1:1]};
            SH_RA:   sh_next = {sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
            default: sh_next = sh_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sh_kind <= SH_LL;
            sh_reg  <= '0;
            sh_cnt  <= '0;
            result  <= '0;
            zero    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            sh_reg  <= op_a;
                            sh_cnt  <= shamt;
                            sh_kind <= sh_kind_in;
                            state   <= S_SHIFT;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            state  <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    sh_reg <= sh_next;
                    sh_cnt <= sh_cnt - SHW'(1);
                    if (sh_cnt == SHW'(1)) begin
                        result <= sh_next;
                        zero   <= (sh_next == '0);
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
